// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: multi-cycle adder/subtractor with accumulator.
// Operands are added CHUNK_BITS per cycle through one shared chunk adder,
// with valid/ready handshakes on both sides and registered result flags.
module seq_addsub_unit #(
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned CHUNK_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in0,
    input  logic [N_BITS-1:0] in1,
    input  logic [1:0]        op,
    input  logic              clear_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out,
    output logic              carry_out,
    output logic              overflow,
    output logic              zero
);

    localparam int unsigned N_CHUNKS = N_BITS / CHUNK_BITS;
    localparam int unsigned K_W      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [K_W-1:0]      k_q;
    logic                c_q;
    logic [N_BITS-1:0]   a_q;
    logic [N_BITS-1:0]   b_q;
    logic [N_BITS-1:0]   r_q;
    logic [N_BITS-1:0]   acc_q;
    logic [N_BITS-1:0]   out_q;
    logic                carry_q;
    logic                ovf_q;
    logic                zero_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [CHUNK_BITS-1:0] a_chunk;
    logic [CHUNK_BITS-1:0] b_chunk;
    logic [CHUNK_BITS:0]   sum;
    logic [N_BITS-1:0]     r_full;
    logic                  last_chunk;

    assign last_chunk = (k_q == K_W'(N_CHUNKS - 1));

    // Select the current chunk, add it, and merge the sum into the partial result
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        r_full  = r_q;
        for (int unsigned i = 0; i < N_CHUNKS; i++) begin
            if (k_q == K_W'(i)) begin
                a_chunk = a_q[i*CHUNK_BITS +: CHUNK_BITS];
                b_chunk = b_q[i*CHUNK_BITS +: CHUNK_BITS];
            end
        end
        sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_BITS{1'b0}}, c_q};
        for (int unsigned i = 0; i < N_CHUNKS; i++) begin
            if (k_q == K_W'(i)) begin
                r_full[i*CHUNK_BITS +: CHUNK_BITS] = sum[CHUNK_BITS-1:0];
            end
        end
    end

    // Next-state logic: accept in IDLE, walk the chunks, wait for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)   state_d = S_CALC;
            S_CALC: if (last_chunk) state_d = S_DONE;
            S_DONE: if (out_ready)  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // State register; handshake outputs are the registered decode of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    // Datapath: latch operands on accept, accumulate chunks, publish result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_acc) acc_q <= '0;
                    if (in_valid) begin
                        // A same-edge clear takes effect before the accumulator is read
                        a_q <= op[1] ? (clear_acc ? '0 : acc_q) : in0;
                        b_q <= in1 ^ {N_BITS{op[0]}};
                        c_q <= op[0];
                        k_q <= '0;
                        r_q <= '0;
                    end
                end
                S_CALC: begin
                    c_q <= sum[CHUNK_BITS];
                    k_q <= k_q + K_W'(1);
                    r_q <= r_full;
                    if (last_chunk) begin
                        out_q   <= r_full;
                        carry_q <= sum[CHUNK_BITS];
                        ovf_q   <= (a_q[N_BITS-1] == b_q[N_BITS-1]) &&
                                   (r_full[N_BITS-1] != a_q[N_BITS-1]);
                        zero_q  <= (r_full == '0);
                        acc_q   <= r_full;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// tb_seq_addsub_unit: directed vectors with literal expectations plus an
// arithmetic reference model checked every cycle on the 8-bit instance.
module tb_seq_addsub_unit;

    localparam int unsigned N8  = 8;
    localparam int unsigned C8  = 4;
    localparam int unsigned LAT = N8 / C8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, clear_acc, out_valid, out_ready;
    logic [7:0] in0, in1, out;
    logic [1:0] op;
    logic       carry_out, overflow, zero;

    logic        v16, rdy16, ov16, ordy16, c16, o16, z16;
    logic [15:0] a16, b16, out16;
    logic [1:0]  op16;

    seq_addsub_unit #(.N_BITS(N8), .CHUNK_BITS(C8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .op(op), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    seq_addsub_unit #(.N_BITS(16), .CHUNK_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
        .in0(a16), .in1(b16), .op(op16), .clear_acc(1'b0),
        .out_valid(ov16), .out_ready(ordy16), .out(out16),
        .carry_out(c16), .overflow(o16), .zero(z16)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int res;
        bit c, v, z;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    int   acc_m = 0;
    bit   armed = 0;
    bit   after_reset = 0;

    function automatic exp_t model(input logic [1:0] o, input int a_in, input int b_in, input int acc);
        exp_t e;
        int ua, ub, sa, sb, full, sr;
        ua = o[1] ? acc : a_in;
        ub = b_in;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (!o[0]) begin
            full = ua + ub; e.c = (full > 255); sr = sa + sb;
        end else begin
            full = ua - ub; e.c = (ua >= ub);   sr = sa - sb;
        end
        e.res = full & 255;
        e.v   = (sr > 127) || (sr < -128);
        e.z   = (e.res == 0);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Compare DUT against the model each cycle, then apply the coming edge's events
    always @(negedge clk) begin
        bit   exp_ov;
        exp_t e;
        exp_ov = (q.size() != 0) && ((cyc - q[0].acc_cyc) >= int'(LAT) + 1);
        if (armed) begin
            check("m_in_ready", in_ready, (q.size() == 0));
            check("m_out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                check("m_out", out, q[0].res);
                check("m_carry", carry_out, q[0].c);
                check("m_ovf", overflow, q[0].v);
                check("m_zero", zero, q[0].z);
            end else if (after_reset) begin
                check("m_rst_out", {out, carry_out, overflow, zero}, 0);
            end
        end
        if (reset) begin
            q.delete();
            acc_m       = 0;
            armed       = 1;
            after_reset = 1;
        end else begin
            after_reset = 0;
            if (q.size() == 0) begin
                if (clear_acc) acc_m = 0;
                if (in_valid) begin
                    e = model(op, int'(in0), int'(in1), acc_m);
                    e.acc_cyc = cyc;
                    q.push_back(e);
                    acc_m = e.res;
                end
            end else if (exp_ov && out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    // ---------------- directed driver ----------------
    task automatic run_op(input string nm, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic clr, input logic calc_clr, input int hold,
                          input logic [7:0] e_out, input logic e_c, input logic e_v, input logic e_z);
        int n;
        bit got;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; in0 = a; in1 = b; clear_acc = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; clear_acc = calc_clr; in0 = 8'h5A; in1 = 8'hA5; op = ~o;
        n = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) got = 1;
        end
        check({nm, "_timeout"}, got, 1);
        check({nm, "_latency"}, n - 1, LAT);
        check({nm, "_out"}, out, e_out);
        check({nm, "_carry"}, carry_out, e_c);
        check({nm, "_ovf"}, overflow, e_v);
        check({nm, "_zero"}, zero, e_z);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            @(negedge clk);
            check({nm, "_hold_out"}, {out, carry_out, overflow, zero}, {e_out, e_c, e_v, e_z});
            check({nm, "_hold_rdy"}, {in_ready, out_valid}, 2'b01);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; clear_acc = 1'b0;
        @(negedge clk);
        check({nm, "_release"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int  n;
        bit  got;
        reset = 1'b1; in_valid = 1'b0; clear_acc = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; op = '0;
        v16 = 1'b0; ordy16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rdy", {in_ready, out_valid}, 2'b10);
        check("rst_flags", {out, carry_out, overflow, zero}, 0);
        check("rst16", {rdy16, ov16, out16, c16, o16, z16}, {2'b10, 16'h0, 3'b000});

        run_op("add_7f_01", 2'b00, 8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 0);
        run_op("sub_05_05", 2'b01, 8'h05, 8'h05, 0, 0, 0, 8'h00, 1, 0, 1);
        run_op("sub_03_05", 2'b01, 8'h03, 8'h05, 0, 0, 0, 8'hFE, 0, 0, 0);
        run_op("sub_80_01", 2'b01, 8'h80, 8'h01, 0, 0, 0, 8'h7F, 1, 1, 0);
        run_op("acc_clr_f0", 2'b10, 8'h33, 8'hF0, 1, 0, 0, 8'hF0, 0, 0, 0);
        run_op("acc_add_20", 2'b10, 8'h33, 8'h20, 0, 0, 0, 8'h10, 1, 0, 0);
        run_op("acc_sub_11", 2'b11, 8'h33, 8'h11, 0, 0, 0, 8'hFF, 0, 0, 0);
        run_op("calc_clr", 2'b00, 8'h12, 8'h34, 0, 1, 0, 8'h46, 0, 0, 0);
        run_op("acc_kept", 2'b10, 8'h00, 8'h01, 0, 0, 0, 8'h47, 0, 0, 0);
        run_op("backpress", 2'b00, 8'h40, 8'h40, 0, 0, 5, 8'h80, 0, 1, 0);

        // Reset on the second CALC edge aborts the operation
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; in0 = 8'h11; in1 = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_rdy", {in_ready, out_valid}, 2'b10);
        check("abort_out", {out, carry_out, overflow, zero}, 0);
        run_op("post_rst_acc", 2'b10, 8'h99, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0);

        // Single-chunk instance: one CALC edge
        @(posedge clk); #1;
        v16 = 1'b1; op16 = 2'b00; a16 = 16'hFFFF; b16 = 16'h0001;
        @(posedge clk); #1;
        v16 = 1'b0; a16 = 16'h1234;
        n = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (ov16) got = 1;
        end
        check("w16_timeout", got, 1);
        check("w16_latency", n - 1, 1);
        check("w16_out", out16, 16'h0000);
        check("w16_flags", {c16, o16, z16}, 3'b101);
        check("w16_rdy", rdy16, 0);
        @(posedge clk); #1 ordy16 = 1'b1;
        @(posedge clk); #1 ordy16 = 1'b0;
        @(negedge clk);
        check("w16_release", {rdy16, ov16}, 2'b10);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
